// File: rtl/de1_sram_pkg.sv
// Shared types and constants for the DE1 SRAM arbiter.
package de1_sram_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW_DEF = 18;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_VID, OWN_CPU} owner_e;

  // Transfer attributes latched at grant time.
  typedef struct packed {
    logic          we;
    logic [1:0]    be;
    logic [DW-1:0] wdata;
  } xfer_t;

endpackage

// File: rtl/de1_sram_dq_io.sv
// SRAM DQ tri-state driver with registered output enable and per-port capture registers.
module de1_sram_dq_io
  import de1_sram_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          oe_d_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          cap_vid_i,
  input  logic          cap_cpu_i,
  output logic [DW-1:0] vid_data_o,
  output logic [DW-1:0] cpu_data_o,
  inout  wire  [DW-1:0] dq_io
);

  logic          oe_q;
  logic [DW-1:0] vid_q;
  logic [DW-1:0] cpu_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oe_q  <= 1'b0;
      vid_q <= '0;
      cpu_q <= '0;
    end else begin
      oe_q <= oe_d_i;
      if (cap_vid_i) vid_q <= dq_io;
      if (cap_cpu_i) cpu_q <= dq_io;
    end
  end

  assign dq_io      = oe_q ? wdata_i : {DW{1'bz}};
  assign vid_data_o = vid_q;
  assign cpu_data_o = cpu_q;

endmodule

// File: rtl/de1_sram_arbiter.sv
// Video/CPU arbiter and fixed-length access sequencer for the DE1 256Kx16 asynchronous SRAM.
module de1_sram_arbiter
  import de1_sram_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iVID_REQ,
  input  logic [AW-1:0] iVID_ADDR,
  output logic          oVID_ACK,
  output logic [DW-1:0] oVID_DATA,
  input  logic          iCPU_REQ,
  input  logic          iCPU_WE,
  input  logic [AW-1:0] iCPU_ADDR,
  input  logic [1:0]    iCPU_BE,
  input  logic [DW-1:0] iCPU_WDATA,
  output logic          oCPU_ACK,
  output logic [DW-1:0] oCPU_RDATA,
  output logic [AW-1:0] oSRAM_ADDR,
  inout  wire  [DW-1:0] ioSRAM_DQ,
  output logic          oSRAM_CE_N,
  output logic          oSRAM_OE_N,
  output logic          oSRAM_WE_N,
  output logic          oSRAM_UB_N,
  output logic          oSRAM_LB_N
);

  localparam int unsigned   CW         = $clog2(WAIT_CYCLES);
  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WAIT_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  owner_e        own_q, own_d;
  logic [AW-1:0] addr_q, addr_d;
  xfer_t         xfer_q, xfer_d;

  logic ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, vid_ack_q, cpu_ack_q;
  logic ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, vid_ack_d, cpu_ack_d;
  logic dq_oe_d, cap_vid_c, cap_cpu_c, cpu_win_c;

  // State register plus all registered pad/ack outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      own_q     <= OWN_VID;
      addr_q    <= '0;
      xfer_q    <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      xfer_q    <= xfer_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      vid_ack_q <= vid_ack_d;
      cpu_ack_q <= cpu_ack_d;
    end
  end

  // Next state, arbitration and grant latching.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    own_d     = own_q;
    addr_d    = addr_q;
    xfer_d    = xfer_q;
    cpu_win_c = iCPU_REQ && (!iVID_REQ || (starve_q == STARVE_MAX));
    unique case (state_q)
      IDLE: begin
        if (iVID_REQ || iCPU_REQ) begin
          state_d = ACCESS;
          cnt_d   = '0;
          if (cpu_win_c) begin
            own_d    = OWN_CPU;
            addr_d   = iCPU_ADDR;
            xfer_d   = '{we: iCPU_WE, be: iCPU_BE, wdata: iCPU_WDATA};
            starve_d = '0;
          end else begin
            own_d  = OWN_VID;
            addr_d = iVID_ADDR;
            xfer_d = '{we: 1'b0, be: 2'b11, wdata: '0};
            if (!iCPU_REQ)                  starve_d = '0;
            else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next-state values so the pads switch on the entering edge.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    ub_n_d    = 1'b1;
    lb_n_d    = 1'b1;
    dq_oe_d   = 1'b0;
    vid_ack_d = (state_d == DONE) && (own_d == OWN_VID);
    cpu_ack_d = (state_d == DONE) && (own_d == OWN_CPU);
    cap_vid_c = (state_q == ACCESS) && (cnt_q == CNT_LAST) && (own_q == OWN_VID);
    cap_cpu_c = (state_q == ACCESS) && (cnt_q == CNT_LAST) && (own_q == OWN_CPU) && !xfer_q.we;
    if (state_d == ACCESS) begin
      ce_n_d = 1'b0;
      ub_n_d = ~xfer_d.be[1];
      lb_n_d = ~xfer_d.be[0];
      if (xfer_d.we) begin
        dq_oe_d = 1'b1;
        we_n_d  = (cnt_d == CNT_LAST) || (xfer_d.be == 2'b00);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  de1_sram_dq_io u_dq (
    .clk_i      (iCLK),
    .rst_ni     (iRST_N),
    .oe_d_i     (dq_oe_d),
    .wdata_i    (xfer_q.wdata),
    .cap_vid_i  (cap_vid_c),
    .cap_cpu_i  (cap_cpu_c),
    .vid_data_o (oVID_DATA),
    .cpu_data_o (oCPU_RDATA),
    .dq_io      (ioSRAM_DQ)
  );

  assign oSRAM_ADDR = addr_q;
  assign oSRAM_CE_N = ce_n_q;
  assign oSRAM_OE_N = oe_n_q;
  assign oSRAM_WE_N = we_n_q;
  assign oSRAM_UB_N = ub_n_q;
  assign oSRAM_LB_N = lb_n_q;
  assign oVID_ACK   = vid_ack_q;
  assign oCPU_ACK   = cpu_ack_q;

endmodule

// File: tb/tb_de1_sram_arbiter.sv
// Self-checking bench: SRAM device model on the pads plus a transaction-level reference memory.
module tb_de1_sram_arbiter;

  localparam int unsigned AW    = 18;
  localparam int unsigned W     = 2;
  localparam int unsigned SL    = 4;
  localparam int          MEMSZ = 1 << AW;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iVID_REQ, iCPU_REQ, iCPU_WE;
  logic [AW-1:0] iVID_ADDR, iCPU_ADDR;
  logic [1:0]    iCPU_BE;
  logic [15:0]   iCPU_WDATA;
  logic          oVID_ACK, oCPU_ACK;
  logic [15:0]   oVID_DATA, oCPU_RDATA;
  logic [AW-1:0] oSRAM_ADDR;
  logic          oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N;
  wire  [15:0]   sram_dq;

  de1_sram_arbiter #(.AW(AW), .WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iVID_REQ(iVID_REQ), .iVID_ADDR(iVID_ADDR), .oVID_ACK(oVID_ACK), .oVID_DATA(oVID_DATA),
    .iCPU_REQ(iCPU_REQ), .iCPU_WE(iCPU_WE), .iCPU_ADDR(iCPU_ADDR), .iCPU_BE(iCPU_BE),
    .iCPU_WDATA(iCPU_WDATA), .oCPU_ACK(oCPU_ACK), .oCPU_RDATA(oCPU_RDATA),
    .oSRAM_ADDR(oSRAM_ADDR), .ioSRAM_DQ(sram_dq),
    .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_WE_N(oSRAM_WE_N),
    .oSRAM_UB_N(oSRAM_UB_N), .oSRAM_LB_N(oSRAM_LB_N)
  );

  always #5 iCLK = ~iCLK;

  int nvec = 0;
  int nerr = 0;
  int we_low_cnt = 0;

  logic [15:0] dev_mem [MEMSZ];
  logic [15:0] ref_mem [MEMSZ];

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 40503 + 17);
  endfunction

  // Asynchronous SRAM device: drives DQ while selected for read, latches bytes while WE_N is low.
  assign sram_dq = (!oSRAM_CE_N && !oSRAM_OE_N) ? dev_mem[oSRAM_ADDR] : 16'hzzzz;

  always @(posedge iCLK) begin
    if (!oSRAM_CE_N && !oSRAM_WE_N) begin
      if (!oSRAM_LB_N) dev_mem[oSRAM_ADDR][7:0]  <= sram_dq[7:0];
      if (!oSRAM_UB_N) dev_mem[oSRAM_ADDR][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge iCLK) if (!oSRAM_WE_N) we_low_cnt++;

  always @(negedge iCLK) begin
    if (iRST_N && dut.u_dq.oe_q && !oSRAM_OE_N) begin
      nvec++;
      nerr++;
      $display("FAIL dq_contention: DQ driven while OE_N=0 at %0t", $time);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [1:0] be,
                          input logic [15:0] wd, output logic [15:0] rd, output int lat,
                          output int wel);
    @(negedge iCLK);
    iCPU_WE = we; iCPU_ADDR = a; iCPU_BE = be; iCPU_WDATA = wd; iCPU_REQ = 1'b1;
    we_low_cnt = 0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge iCLK);
      if (oCPU_ACK) begin lat = n; break; end
    end
    iCPU_REQ = 1'b0;
    rd  = oCPU_RDATA;
    wel = we_low_cnt;
    if (lat != 0 && we)
      for (int b = 0; b < 2; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic vid_xfer(input logic [AW-1:0] a, output logic [15:0] rd, output int lat);
    @(negedge iCLK);
    iVID_ADDR = a; iVID_REQ = 1'b1;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge iCLK);
      if (oVID_ACK) begin lat = n; break; end
    end
    iVID_REQ = 1'b0;
    rd = oVID_DATA;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [1:0]    be;
    logic [15:0]   wd;
    logic [15:0]   exp_rd;
    int            exp_wel;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [15:0] rd, rd2, exp_cpu_rd, exp_vid, e;
    logic [AW-1:0] a;
    logic          we, exp_c;
    logic [1:0]    be;
    int            lat, lat2, wel, vrun, cwait, acks, ncpu;

    tbl[0] = '{1'b1, 18'h12345, 2'b11, 16'hBEEF, 16'h0000, 1};
    tbl[1] = '{1'b0, 18'h12345, 2'b11, 16'h0000, 16'hBEEF, 0};
    tbl[2] = '{1'b1, 18'h12345, 2'b01, 16'h00AA, 16'hBEEF, 1};
    tbl[3] = '{1'b0, 18'h12345, 2'b11, 16'h0000, 16'hBEAA, 0};
    tbl[4] = '{1'b1, 18'h12345, 2'b00, 16'h1111, 16'hBEAA, 0};
    tbl[5] = '{1'b0, 18'h12345, 2'b11, 16'h0000, 16'hBEAA, 0};
    tbl[6] = '{1'b1, 18'h12345, 2'b10, 16'h5500, 16'hBEAA, 1};
    tbl[7] = '{1'b0, 18'h12345, 2'b11, 16'h0000, 16'h55AA, 0};

    for (int i = 0; i < MEMSZ; i++) begin
      dev_mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    iRST_N = 1'b0;
    iVID_REQ = 1'b0; iVID_ADDR = '0;
    iCPU_REQ = 1'b0; iCPU_WE = 1'b0; iCPU_ADDR = '0; iCPU_BE = 2'b00; iCPU_WDATA = '0;
    repeat (3) @(negedge iCLK);

    chk("rst_ce_n", 32'(oSRAM_CE_N), 32'd1);
    chk("rst_oe_n", 32'(oSRAM_OE_N), 32'd1);
    chk("rst_we_n", 32'(oSRAM_WE_N), 32'd1);
    chk("rst_ublb_n", 32'({oSRAM_UB_N, oSRAM_LB_N}), 32'd3);
    chk("rst_addr", 32'(oSRAM_ADDR), 32'd0);
    chk("rst_acks", 32'({oVID_ACK, oCPU_ACK}), 32'd0);
    chk("rst_vid_data", 32'(oVID_DATA), 32'd0);
    chk("rst_cpu_rdata", 32'(oCPU_RDATA), 32'd0);
    iRST_N = 1'b1;

    // Reset asserted in the middle of a write access.
    @(negedge iCLK);
    iCPU_WE = 1'b1; iCPU_ADDR = 18'h3FFF0; iCPU_BE = 2'b11; iCPU_WDATA = 16'h1234; iCPU_REQ = 1'b1;
    @(negedge iCLK);
    chk("mid_we_n_low", 32'(oSRAM_WE_N), 32'd0);
    chk("mid_dq_driven", 32'(dut.u_dq.oe_q), 32'd1);
    #2 iRST_N = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'h1F);
    chk("mid_rst_dq_released", 32'(dut.u_dq.oe_q), 32'd0);
    iCPU_REQ = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    vid_xfer(18'h00010, rd, lat);
    chk("post_rst_vid_lat", 32'(lat), 32'd3);
    chk("post_rst_vid_data", 32'(rd), 32'(ref_mem[16]));

    // Byte-enabled write/read table.
    for (int i = 0; i < 8; i++) begin
      cpu_xfer(tbl[i].we, tbl[i].a, tbl[i].be, tbl[i].wd, rd, lat, wel);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_we_low_cycles", i), 32'(wel), 32'(tbl[i].exp_wel));
    end

    // Back-to-back video reads with REQ held high.
    @(negedge iCLK);
    iVID_ADDR = '0; iVID_REQ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge iCLK);
        if (oVID_ACK) begin lat = n; break; end
      end
      chk($sformatf("b2b%0d_gap", k), 32'(lat), (k == 0) ? 32'd3 : 32'd4);
      chk($sformatf("b2b%0d_data", k), 32'(oVID_DATA), 32'(ref_mem[k]));
      iVID_ADDR = AW'(k + 1);
      if (k == 3) iVID_REQ = 1'b0;
    end

    // Both ports requesting continuously: CPU gets every (SL+1)th grant.
    @(negedge iCLK);
    iVID_ADDR = 18'h00005; iVID_REQ = 1'b1;
    iCPU_WE = 1'b0; iCPU_ADDR = 18'h00007; iCPU_BE = 2'b11; iCPU_REQ = 1'b1;
    vrun = 0; cwait = 0; acks = 0; ncpu = 0;
    for (int n = 0; n < 200 && acks < 10; n++) begin
      @(negedge iCLK);
      cwait++;
      if (oVID_ACK || oCPU_ACK) begin
        exp_c = (vrun == int'(SL));
        chk($sformatf("order%0d_is_cpu", acks), 32'(oCPU_ACK), 32'(exp_c));
        if (oCPU_ACK) begin
          chk($sformatf("cpu_wait%0d", ncpu), 32'(cwait),
              (ncpu == 0) ? 32'(SL * (W + 2) + W + 1) : 32'(SL * (W + 2) + W + 2));
          chk($sformatf("starve_cpu_data%0d", ncpu), 32'(oCPU_RDATA), 32'(ref_mem[7]));
          vrun = 0; cwait = 0; ncpu++;
        end else begin
          chk($sformatf("starve_vid_data%0d", acks), 32'(oVID_DATA), 32'(ref_mem[5]));
          vrun++;
        end
        acks++;
        if (acks == 10) begin iVID_REQ = 1'b0; iCPU_REQ = 1'b0; end
      end
    end
    iVID_REQ = 1'b0; iCPU_REQ = 1'b0;
    chk("starve_acks_seen", 32'(acks), 32'd10);
    repeat (3) @(negedge iCLK);

    // Simultaneous first requests straight after reset: video first, CPU right after DONE.
    iRST_N = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    chk("rst2_data", 32'({oVID_DATA, oCPU_RDATA}), 32'd0);
    fork
      vid_xfer(18'h00020, rd, lat);
      cpu_xfer(1'b0, 18'h00021, 2'b11, 16'h0000, rd2, lat2, wel);
    join
    chk("sim_vid_lat", 32'(lat), 32'd3);
    chk("sim_cpu_lat", 32'(lat2), 32'd7);
    chk("sim_vid_data", 32'(rd), 32'(ref_mem[32]));
    chk("sim_cpu_data", 32'(rd2), 32'(ref_mem[33]));
    exp_vid = ref_mem[32];
    exp_cpu_rd = ref_mem[33];

    // Random single transfers against the reference memory.
    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        we = 1'($urandom_range(0, 1));
        be = we ? 2'($urandom_range(0, 3)) : 2'b11;
        e  = we ? exp_cpu_rd : ref_mem[a];
        cpu_xfer(we, a, be, 16'($urandom), rd, lat, wel);
        chk($sformatf("rnd%0d_cpu_lat", i), 32'(lat), 32'd3);
        chk($sformatf("rnd%0d_cpu_rdata", i), 32'(rd), 32'(e));
        chk($sformatf("rnd%0d_vid_held", i), 32'(oVID_DATA), 32'(exp_vid));
        exp_cpu_rd = e;
      end else begin
        e = ref_mem[a];
        vid_xfer(a, rd, lat);
        chk($sformatf("rnd%0d_vid_lat", i), 32'(lat), 32'd3);
        chk($sformatf("rnd%0d_vid_data", i), 32'(rd), 32'(e));
        chk($sformatf("rnd%0d_cpu_held", i), 32'(oCPU_RDATA), 32'(exp_cpu_rd));
        exp_vid = e;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
